// File: rtl/flac_pkg.sv
// Shared types and constants for the FLAC fixed-predictor Rice encoder.
package flac_pkg;

    localparam int MAX_ORDER = 4;
    localparam int ORDER_W   = 3;
    localparam int RICE_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RESIDUAL,
        ST_FLUSH,
        ST_DONE
    } flac_state_t;

endpackage

// File: rtl/flac_bit_packer.sv
// MSB-first bit packer: appends variable-length bit groups and emits
// OUT_W-bit words with valid/ready backpressure and a zero-padded final word.
module flac_bit_packer #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_bits,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_flush,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_word,
    output logic             o_word_valid,
    output logic             o_last_word,
    input  logic             i_word_ready,
    output logic             o_empty
);

    localparam int ACC_W  = OUT_W + IN_W;
    localparam int CNT_PW = $clog2(ACC_W + 1);
    localparam logic [CNT_PW-1:0] OUT_W_C = CNT_PW'(OUT_W);

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_PW-1:0] r_fill;

    logic [IN_W-1:0]   w_left;
    logic [ACC_W-1:0]  w_ins;
    logic              w_full;
    logic              w_pop;

    // Left-align the group, then drop it just below the bits already held.
    assign w_left       = i_bits << (LEN_W'(IN_W) - i_len);
    assign w_ins        = {w_left, {OUT_W{1'b0}}} >> r_fill;

    assign w_full       = (r_fill >= OUT_W_C);
    assign o_word_valid = w_full || (i_flush && (r_fill != '0));
    assign o_last_word  = o_word_valid && i_flush && (r_fill <= OUT_W_C);
    assign o_word       = r_acc[ACC_W-1 -: OUT_W];
    assign o_ready      = !w_full && !i_flush;
    assign o_empty      = (r_fill == '0);
    assign w_pop        = o_word_valid && i_word_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_pop) begin
            r_acc  <= r_acc << OUT_W;
            r_fill <= w_full ? (r_fill - OUT_W_C) : '0;
        end else if (i_valid && o_ready) begin
            r_acc  <= r_acc | w_ins;
            r_fill <= r_fill + CNT_PW'(i_len);
        end
    end

endmodule

// File: rtl/flac_fixed_rice_encoder.sv
// FLAC fixed-predictor residual encoder: verbatim warmup samples followed by
// Rice-coded residuals, packed MSB first into OUT_W-bit words.
module flac_fixed_rice_encoder
    import flac_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                iClock,
    input  logic                iReset_n,
    input  logic                iStart,
    input  logic [ORDER_W-1:0]  iOrder,
    input  logic [RICE_W-1:0]   iRiceParam,
    input  logic [CNT_W-1:0]    iNumSamples,
    input  logic [SAMPLE_W-1:0] iSample,
    input  logic                iSampleValid,
    output logic                oSampleReady,
    output logic [OUT_W-1:0]    oWord,
    output logic                oWordValid,
    input  logic                iWordReady,
    output logic                oLastWord,
    output logic [CNT_W+7:0]    oBitCount,
    output logic                oDone,
    output logic                oError
);

    localparam int U_W   = SAMPLE_W + 4;
    localparam int IN_W  = (SAMPLE_W > OUT_W) ? SAMPLE_W : OUT_W;
    localparam int LEN_W = $clog2(IN_W + 1);
    localparam int BC_W  = CNT_W + 8;
    localparam logic [U_W-1:0] OUT_W_U = U_W'(OUT_W);

    flac_state_t         r_state;
    logic [ORDER_W-1:0]  r_order;
    logic [RICE_W-1:0]   r_k;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_warm;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic [U_W-1:0]      r_q;
    logic [IN_W-1:0]     r_rem;
    logic                r_error;
    logic [BC_W-1:0]     r_bitcnt;
    logic signed [U_W-1:0] r_hist [1:MAX_ORDER];

    logic signed [U_W-1:0] w_x0;
    logic signed [U_W-1:0] w_res;
    logic [U_W-1:0]      w_u;
    logic [U_W-1:0]      w_q_new;
    logic [LEN_W-1:0]    w_chunk;
    logic [IN_W-1:0]     w_one_k;
    logic [IN_W-1:0]     w_stop;
    logic                w_accept;
    logic                w_pk_valid;
    logic [IN_W-1:0]     w_pk_bits;
    logic [LEN_W-1:0]    w_pk_len;
    logic                w_pk_ready;
    logic                w_pk_empty;
    logic                w_push;

    assign oSampleReady = w_pk_ready &&
        (((r_state == ST_WARMUP) && (r_cnt < r_warm)) ||
         ((r_state == ST_RESIDUAL) && !r_busy && (r_cnt < r_num)));
    assign w_accept = oSampleReady && iSampleValid;

    assign w_x0 = signed'({{4{iSample[SAMPLE_W-1]}}, iSample});

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_res = w_x0;
        case (r_order)
            3'd1:    w_res = w_x0 - r_hist[1];
            3'd2:    w_res = w_x0 - (r_hist[1] <<< 1) + r_hist[2];
            3'd3:    w_res = w_x0 - ((r_hist[1] <<< 1) + r_hist[1])
                                  + ((r_hist[2] <<< 1) + r_hist[2]) - r_hist[3];
            3'd4:    w_res = w_x0 - (r_hist[1] <<< 2)
                                  + ((r_hist[2] <<< 2) + (r_hist[2] <<< 1))
                                  - (r_hist[3] <<< 2) + r_hist[4];
            default: w_res = w_x0;
        endcase
    end

    // Zigzag fold: r>=0 -> 2r, r<0 -> -2r-1.
    assign w_u     = {w_res[U_W-2:0], 1'b0} ^ {U_W{w_res[U_W-1]}};
    assign w_q_new = w_u >> r_k;

    assign w_chunk = (r_q >= OUT_W_U) ? LEN_W'(OUT_W) : LEN_W'(r_q);
    assign w_one_k = IN_W'(1) << r_k;
    assign w_stop  = w_one_k | (r_rem & (w_one_k - IN_W'(1)));

    always_comb begin
        w_pk_valid = 1'b0;
        w_pk_bits  = '0;
        w_pk_len   = '0;
        if ((r_state == ST_WARMUP) && w_accept) begin
            w_pk_valid = 1'b1;
            w_pk_bits  = IN_W'(iSample);
            w_pk_len   = LEN_W'(SAMPLE_W);
        end else if ((r_state == ST_RESIDUAL) && r_busy) begin
            w_pk_valid = 1'b1;
            if (r_q != '0) begin
                w_pk_len  = w_chunk;
            end else begin
                w_pk_bits = w_stop;
                w_pk_len  = LEN_W'(r_k) + LEN_W'(1);
            end
        end
    end

    assign w_push = w_pk_valid && w_pk_ready;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state  <= ST_IDLE;
            r_order  <= '0;
            r_k      <= '0;
            r_num    <= '0;
            r_warm   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_q      <= '0;
            r_rem    <= '0;
            r_error  <= 1'b0;
            r_bitcnt <= '0;
            // NOTE: the small history array is reset like any register; a
            // large RAM would normally be left unreset.
            for (int i = 1; i <= MAX_ORDER; i++) r_hist[i] <= '0;
        end else begin
            if (w_push) r_bitcnt <= r_bitcnt + BC_W'(w_pk_len);
            if (w_accept) begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_hist[1] <= w_x0;
                for (int i = 2; i <= MAX_ORDER; i++) r_hist[i] <= r_hist[i-1];
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (iStart) begin
                        r_order  <= iOrder;
                        r_k      <= iRiceParam;
                        r_num    <= iNumSamples;
                        r_warm   <= (CNT_W'(iOrder) < iNumSamples) ? CNT_W'(iOrder) : iNumSamples;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_bitcnt <= '0;
                        r_error  <= 1'b0;
                        if (iNumSamples == '0) begin
                            r_state <= ST_DONE;
                        end else if ((int'(iOrder) > MAX_ORDER) ||
                                     (int'(iRiceParam) > SAMPLE_W - 1)) begin
                            r_state <= ST_DONE;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_WARMUP;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (r_warm == '0) begin
                        r_state <= ST_RESIDUAL;
                    end else if (w_accept && (r_cnt + CNT_W'(1) == r_warm)) begin
                        r_state <= (r_warm == r_num) ? ST_FLUSH : ST_RESIDUAL;
                    end
                end
                ST_RESIDUAL: begin
                    if (w_accept) begin
                        r_q    <= w_q_new;
                        r_rem  <= IN_W'(w_u);
                        r_busy <= 1'b1;
                    end else if (r_busy && w_pk_ready) begin
                        if (r_q != '0) begin
                            r_q <= r_q - U_W'(w_chunk);
                        end else begin
                            r_busy <= 1'b0;
                            if (r_cnt == r_num) r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_pk_empty) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    flac_bit_packer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LEN_W (LEN_W)
    ) u_packer (
        .i_clk        (iClock),
        .i_rst_n      (iReset_n),
        .i_valid      (w_pk_valid),
        .i_bits       (w_pk_bits),
        .i_len        (w_pk_len),
        .i_flush      (r_state == ST_FLUSH),
        .o_ready      (w_pk_ready),
        .o_word       (oWord),
        .o_word_valid (oWordValid),
        .o_last_word  (oLastWord),
        .i_word_ready (iWordReady),
        .o_empty      (w_pk_empty)
    );

    assign oBitCount = r_bitcnt;
    assign oDone     = (r_state == ST_DONE);
    assign oError    = oDone && r_error;

endmodule
